// File: rtl/eeprom_cmd_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// eeprom_cmd_sched : UART command parser and I2C EEPROM request scheduler
//                    with write-cycle (tWR) hold-off and completion timeout.
// Revision: 1.0
// ============================================================================

module eeprom_cmd_sched #(
  parameter int SYS_CLK     = 50_000_000,
  parameter int TWR_US      = 5000,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       i2c_wr,
  output logic       i2c_rd,
  output logic [7:0] i2c_addr,
  output logic [7:0] i2c_wdata,
  input  logic       i2c_done,
  input  logic       i2c_ack_err,
  input  logic [7:0] i2c_rdata,
  output logic       busy,
  output logic       rx_overrun
);

  localparam int TWR_CYC = SYS_CLK / 1_000_000 * TWR_US;
  localparam int TWR_W   = $clog2(TWR_CYC + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [TWR_W-1:0] TWR_LOAD = TWR_W'(TWR_CYC);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [7:0] OP_WR    = 8'h57;
  localparam logic [7:0] OP_RD    = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_NACK = 8'h45;
  localparam logic [7:0] RSP_TO   = 8'h54;
  localparam logic [7:0] RSP_BAD  = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GET_ADDR  = 3'd1,
    S_GET_DATA  = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_RESP      = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic             is_wr_q, is_wr_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [TWR_W-1:0] twr_cnt_q, twr_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             wr_pulse_q, wr_pulse_d;
  logic             rd_pulse_q, rd_pulse_d;
  logic             overrun_q, overrun_d;
  logic             req_pulse;

  assign req_pulse = wr_pulse_q | rd_pulse_q;

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_data_d  = tx_data_q;
    to_cnt_d   = to_cnt_q;
    wr_pulse_d = 1'b0;
    rd_pulse_d = 1'b0;
    overrun_d  = 1'b0;
    // tWR countdown runs regardless of state; a good write reloads it below
    twr_cnt_d  = (twr_cnt_q != '0) ? twr_cnt_q - TWR_W'(1) : '0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == OP_WR) begin
            is_wr_d = 1'b1;
            state_d = S_GET_ADDR;
          end else if (rx_data == OP_RD) begin
            is_wr_d = 1'b0;
            state_d = S_GET_ADDR;
          end else begin
            tx_data_d = RSP_BAD;
            state_d   = S_RESP;
          end
        end
      end

      S_GET_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data;
          state_d = is_wr_q ? S_GET_DATA : S_ISSUE;
        end
      end

      S_GET_DATA: begin
        if (rx_valid) begin
          wdata_d = rx_data;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        overrun_d = rx_valid;
        if (twr_cnt_q == '0) begin
          wr_pulse_d = is_wr_q;
          rd_pulse_d = ~is_wr_q;
          to_cnt_d   = '0;
          state_d    = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        overrun_d = rx_valid;
        if (i2c_done) begin
          if (i2c_ack_err) begin
            tx_data_d = RSP_NACK;
          end else if (is_wr_q) begin
            tx_data_d = RSP_OK;
            twr_cnt_d = TWR_LOAD;
          end else begin
            tx_data_d = i2c_rdata;
          end
          state_d = S_RESP;
        end else if (!req_pulse && to_cnt_q == TO_LAST) begin
          tx_data_d = RSP_TO;
          state_d   = S_RESP;
        end else if (!req_pulse) begin
          // counting starts the cycle after the request pulse
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_RESP: begin
        overrun_d = rx_valid;
        if (tx_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tx_data_q  <= '0;
      twr_cnt_q  <= '0;
      to_cnt_q   <= '0;
      wr_pulse_q <= 1'b0;
      rd_pulse_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_data_q  <= tx_data_d;
      twr_cnt_q  <= twr_cnt_d;
      to_cnt_q   <= to_cnt_d;
      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
      overrun_q  <= overrun_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = (state_q == S_RESP);
  assign i2c_wr     = wr_pulse_q;
  assign i2c_rd     = rd_pulse_q;
  assign i2c_addr   = addr_q;
  assign i2c_wdata  = wdata_q;
  assign busy       = (state_q != S_IDLE);
  assign rx_overrun = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_eeprom_cmd_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_eeprom_cmd_sched : randomized self-checking bench with EEPROM/I2C model.
// Revision: 1.0
// ============================================================================

module tb_eeprom_cmd_sched;

  localparam int SYS_CLK     = 1_000_000;
  localparam int TWR_US      = 2000;
  localparam int TIMEOUT_CYC = 1000;
  localparam int TWR_CYC     = SYS_CLK / 1_000_000 * TWR_US;
  localparam longint NO_WRITE = -1_000_000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       i2c_wr, i2c_rd;
  logic [7:0] i2c_addr, i2c_wdata;
  logic       i2c_done = 1'b0;
  logic       i2c_ack_err = 1'b0;
  logic [7:0] i2c_rdata = 8'h00;
  logic       busy, rx_overrun;

  eeprom_cmd_sched #(
    .SYS_CLK(SYS_CLK), .TWR_US(TWR_US), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .i2c_wr(i2c_wr), .i2c_rd(i2c_rd), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
    .i2c_done(i2c_done), .i2c_ack_err(i2c_ack_err), .i2c_rdata(i2c_rdata),
    .busy(busy), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // observed pulse-cycle counts
  int n_wr_seen = 0, n_rd_seen = 0, n_ovr_seen = 0;
  always @(negedge clk) begin
    if (i2c_wr)     n_wr_seen++;
    if (i2c_rd)     n_rd_seen++;
    if (rx_overrun) n_ovr_seen++;
  end

  // reference model: EEPROM contents, expected pulse counts, last good write
  logic [7:0] mem [256];
  int         exp_wr = 0, exp_rd = 0, exp_ovr = 0;
  longint     wr_done = NO_WRITE;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic summary_and_stop();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "bench aborted");
  endtask

  task automatic send_byte(input logic [7:0] b, output longint c);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1; c = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_pulse(output longint pc, output bit is_w, output bit ok);
    ok = 1'b0; pc = 0; is_w = 1'b0;
    for (int i = 0; i < TWR_CYC + 20 && !ok; i++) begin
      @(negedge clk);
      if (i2c_wr || i2c_rd) begin
        pc = cyc; is_w = i2c_wr; ok = 1'b1;
      end
    end
    if (!ok) chk("pulse_wait_expired", 0, 1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_tx", {tx_valid, tx_data}, 0);
    chk("rst_i2c", {i2c_wr, i2c_rd, i2c_addr, i2c_wdata}, 0);
    chk("rst_busy_ovr", {busy, rx_overrun}, 0);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_no_wr", n_wr_seen, exp_wr);
    chk("rst_no_rd", n_rd_seen, exp_rd);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr_done = NO_WRITE;
  endtask

  task automatic finish_resp(input logic [7:0] exp, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", tx_valid, 1);
      chk("hold_data", tx_data, exp);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_valid", tx_valid, 0);
  endtask

  task automatic spurious_done();
    @(posedge clk); #1;
    i2c_done = 1'b1; i2c_ack_err = 1'b0;
    @(posedge clk); #1;
    i2c_done = 1'b0;
  endtask

  // mode: 0 acknowledged, 1 NACK, 2 no completion (timeout)
  task automatic run_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d,
                         input int mode, input int dly, input bit inj, input int hold);
    longint c0, cl, pc, dc, tv, exp_pc;
    bit is_w, ok;
    logic [7:0] exp_rsp, rd;
    send_byte(op, c0);
    @(negedge clk);
    chk("busy_after_op", busy, 1);
    if (op != 8'h57 && op != 8'h52) begin
      chk("bad_op_valid", tx_valid, 1);
      chk("bad_op_data", tx_data, 8'h3F);
      finish_resp(8'h3F, hold);
    end else begin
      send_byte(a, cl);
      if (op == 8'h57) send_byte(d, cl);
      exp_pc = (cl + 2 > wr_done + TWR_CYC + 2) ? cl + 2 : wr_done + TWR_CYC + 2;
      wait_pulse(pc, is_w, ok);
      if (!ok) summary_and_stop();
      chk("pulse_cycle", 32'(pc), 32'(exp_pc));
      chk("pulse_kind", is_w, (op == 8'h57));
      chk("req_addr", i2c_addr, a);
      if (op == 8'h57) begin
        chk("req_wdata", i2c_wdata, d);
        exp_wr++;
      end else begin
        exp_rd++;
      end
      if (inj) begin
        @(posedge clk); #1;
        rx_data = 8'($urandom); rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        exp_ovr++;
        @(negedge clk); #1;
        chk("overrun_pulse", n_ovr_seen, exp_ovr);
      end
      repeat (dly) @(posedge clk);
      if (mode == 2) begin
        tv = 0;
        for (int i = 0; i < TIMEOUT_CYC + 50 && tv == 0; i++) begin
          @(negedge clk);
          if (tx_valid) tv = cyc;
        end
        chk("timeout_cycle", 32'(tv), 32'(pc + TIMEOUT_CYC + 1));
        exp_rsp = 8'h54;
        chk("timeout_data", tx_data, exp_rsp);
      end else begin
        @(posedge clk); #1;
        chk("addr_stable", i2c_addr, a);
        if (op == 8'h57) chk("wdata_stable", i2c_wdata, d);
        rd = (mode == 1) ? 8'($urandom) : mem[a];
        i2c_done = 1'b1; i2c_ack_err = (mode == 1); i2c_rdata = rd;
        dc = cyc;
        @(posedge clk); #1;
        i2c_done = 1'b0; i2c_ack_err = 1'b0; i2c_rdata = 8'($urandom);
        @(negedge clk);
        if (mode == 1)         exp_rsp = 8'h45;
        else if (op == 8'h57)  exp_rsp = 8'h4B;
        else                   exp_rsp = mem[a];
        chk("rsp_valid", tx_valid, 1);
        chk("rsp_data", tx_data, exp_rsp);
        if (mode == 0 && op == 8'h57) begin
          mem[a]  = d;
          wr_done = dc;
        end
      end
      finish_resp(exp_rsp, hold);
    end
    #1;
    chk("wr_count", n_wr_seen, exp_wr);
    chk("rd_count", n_rd_seen, exp_rd);
  endtask

  task automatic reset_mid_wait();
    longint c, cl, exp_pc, pc;
    bit is_w, ok;
    send_byte(8'h57, c);
    send_byte(8'h60, c);
    send_byte(8'h99, cl);
    exp_pc = (cl + 2 > wr_done + TWR_CYC + 2) ? cl + 2 : wr_done + TWR_CYC + 2;
    wait_pulse(pc, is_w, ok);
    if (!ok) summary_and_stop();
    chk("rw_pulse_cycle", 32'(pc), 32'(exp_pc));
    exp_wr++;
    repeat (3) @(posedge clk);
    reset_pulse();
  endtask

  task automatic reset_mid_issue();
    longint c;
    run_cmd(8'h57, 8'h50, 8'h77, 0, 2, 1'b0, 0);
    send_byte(8'h52, c);
    send_byte(8'h50, c);
    repeat (5) @(negedge clk);
    chk("blocked_busy", busy, 1);
    #1 chk("blocked_no_rd", n_rd_seen, exp_rd);
    reset_pulse();
    run_cmd(8'h52, 8'h50, 8'h00, 0, 3, 1'b0, 0);
  endtask

  initial begin
    #(900_000 * 10);
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    summary_and_stop();
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs();

    run_cmd(8'h57, 8'h10, 8'hA5, 0, 100, 1'b0, 0);
    run_cmd(8'h52, 8'h10, 8'h00, 0, 5, 1'b0, 0);
    run_cmd(8'h52, 8'h20, 8'h00, 1, 3, 1'b0, 0);
    run_cmd(8'h57, 8'h21, 8'h5A, 0, 2, 1'b0, 0);
    run_cmd(8'h57, 8'h30, 8'h11, 2, 0, 1'b0, 0);
    run_cmd(8'h57, 8'h31, 8'h22, 0, 1, 1'b0, 0);
    run_cmd(8'h00, 8'h00, 8'h00, 0, 0, 1'b0, 1);
    run_cmd(8'h57, 8'h40, 8'hC3, 0, 10, 1'b1, 0);
    run_cmd(8'h57, 8'h41, 8'h3C, 0, 4, 1'b0, 50);
    run_cmd(8'h52, 8'h41, 8'h00, 0, 0, 1'b0, 2);
    reset_mid_wait();
    reset_mid_issue();

    for (int k = 0; k < 30; k++) begin
      int         sel, mode;
      logic [7:0] op;
      sel = $urandom_range(0, 9);
      if (sel < 4)      op = 8'h57;
      else if (sel < 8) op = 8'h52;
      else begin
        op = 8'($urandom);
        if (op == 8'h57 || op == 8'h52) op = 8'h00;
      end
      sel = $urandom_range(0, 19);
      mode = (sel < 2) ? 2 : (sel < 5) ? 1 : 0;
      if ($urandom_range(0, 4) == 0) spurious_done();
      run_cmd(op, 8'h10 + 8'($urandom_range(0, 7)), 8'($urandom), mode,
              $urandom_range(0, 40), ($urandom_range(0, 4) == 0), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
